// File: rtl/program_mem_arbiter_pkg.sv
// Shared types for the program-memory read arbiter.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package program_mem_arbiter_pkg;

    // Arbiter sequencing: wait for a fetcher, wait for memory, deliver the pulse.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_REQ   = 2'd1,
        ARB_REPLY = 2'd2
    } progmem_arb_state_t;

    // Width of a consumer index; a single consumer still gets a 1-bit pointer.
    function automatic int ptr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/program_mem_arbiter_rr_picker.sv
// Round-robin priority encoder: first set bit of eligible_i at or after rr_ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; found_o=0 when nothing is eligible.
module rr_picker
    import program_mem_arbiter_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int PTR_W         = ptr_bits(NUM_CONSUMERS)
) (
    input  logic [NUM_CONSUMERS-1:0] eligible_i,
    input  logic [PTR_W-1:0]         rr_ptr_i,
    output logic                     found_o,
    output logic [PTR_W-1:0]         grant_o
);

    logic [PTR_W-1:0] idx;

    // Scan offsets from farthest to nearest so the nearest eligible index wins last.
    always_comb begin
        found_o = 1'b0;
        grant_o = '0;
        idx     = '0;
        for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(rr_ptr_i) + k) % NUM_CONSUMERS);
            if (eligible_i[idx]) begin
                found_o = 1'b1;
                grant_o = idx;
            end
        end
    end

endmodule

// File: rtl/program_mem_arbiter.sv
// Round-robin arbiter sharing one program-memory read port among NUM_CONSUMERS fetchers.
// Latency: request on the memory port the cycle after grant; ready pulse the cycle after mem_read_ready.
// Backpressure: fetchers hold valid until their one-cycle ready pulse; memory stalls by withholding mem_read_ready.
module program_mem_arbiter
    import program_mem_arbiter_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    output logic                                     mem_read_valid,
    output logic [ADDR_BITS-1:0]                     mem_read_address,
    input  logic                                     mem_read_ready,
    input  logic [DATA_BITS-1:0]                     mem_read_data
);

    localparam int               PTR_W = ptr_bits(NUM_CONSUMERS);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_CONSUMERS - 1);

    progmem_arb_state_t                      state_q;
    logic [PTR_W-1:0]                        grant_q;
    logic [PTR_W-1:0]                        rr_ptr_q;
    logic [PTR_W-1:0]                        rr_ptr_d;
    logic                                    mem_valid_q;
    logic [ADDR_BITS-1:0]                    mem_addr_q;
    logic [NUM_CONSUMERS-1:0]                ready_q;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] data_q;

    logic [NUM_CONSUMERS-1:0] eligible;
    logic                     pick_found;
    logic [PTR_W-1:0]         pick_grant;

    // A consumer still showing its ready pulse must not be re-accepted on the same edge.
    assign eligible = consumer_read_valid & ~ready_q;

    // Search restarts just past the consumer served last.
    assign rr_ptr_d = (grant_q == LAST) ? '0 : grant_q + 1'b1;

    rr_picker #(
        .NUM_CONSUMERS (NUM_CONSUMERS),
        .PTR_W         (PTR_W)
    ) u_picker (
        .eligible_i (eligible),
        .rr_ptr_i   (rr_ptr_q),
        .found_o    (pick_found),
        .grant_o    (pick_grant)
    );

    // Grant, forward to memory, return data as a single-cycle pulse, then re-arbitrate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            ready_q     <= '0;
            data_q      <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant_q     <= pick_grant;
                        mem_addr_q  <= consumer_read_address[pick_grant];
                        mem_valid_q <= 1'b1;
                        state_q     <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (mem_read_ready) begin
                        mem_valid_q      <= 1'b0;
                        data_q[grant_q]  <= mem_read_data;
                        ready_q[grant_q] <= 1'b1;
                        rr_ptr_q         <= rr_ptr_d;
                        state_q          <= ARB_REPLY;
                    end
                end
                ARB_REPLY: begin
                    ready_q[grant_q] <= 1'b0;
                    state_q          <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign consumer_read_ready = ready_q;
    assign consumer_read_data  = data_q;
    assign mem_read_valid      = mem_valid_q;
    assign mem_read_address    = mem_addr_q;

endmodule

// File: tb/tb_program_mem_arbiter.sv
// Self-checking bench for program_mem_arbiter: directed scenarios plus randomized fetchers vs a transaction model.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: fetchers drop valid on or one edge after their ready pulse; memory ready is randomized.
module tb_program_mem_arbiter;

    localparam int AB = 8;
    localparam int DB = 16;
    localparam int N  = 4;

    logic                 clk   = 1'b0;
    logic                 reset = 1'b0;
    logic [N-1:0]         valid = '0;
    logic [N-1:0][AB-1:0] addr  = '0;
    logic [N-1:0]         rdy;
    logic [N-1:0][DB-1:0] rdata;
    logic                 mvld;
    logic [AB-1:0]        maddr;
    logic                 mrdy  = 1'b0;
    logic [DB-1:0]        mdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    program_mem_arbiter #(
        .ADDR_BITS     (AB),
        .DATA_BITS     (DB),
        .NUM_CONSUMERS (N)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (valid),
        .consumer_read_address (addr),
        .consumer_read_ready   (rdy),
        .consumer_read_data    (rdata),
        .mem_read_valid        (mvld),
        .mem_read_address      (maddr),
        .mem_read_ready        (mrdy),
        .mem_read_data         (mdata)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        valid = '0;
        addr  = '0;
        mrdy  = 1'b0;
        mdata = '0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    // Bounded wait for a memory request; the caller judges the outcome.
    task automatic wait_req(output bit seen);
        int n;
        n = 0;
        while (mvld !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        seen = (mvld === 1'b1);
    endtask

    // Called on the falling edge after the grant edge; memory answers on the k-th edge after it.
    task automatic respond(input int k, input logic [DB-1:0] d);
        repeat (k - 1) tick();
        mrdy  = 1'b1;
        mdata = d;
        tick();
        mrdy  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rdy !== '0)   begin errors++; $display("FAIL reset_ready got=%b exp=0", rdy); end
        checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", rdata); end
        checks++; if (mvld !== 1'b0) begin errors++; $display("FAIL reset_mvld got=%b exp=0", mvld); end
        checks++; if (maddr !== '0) begin errors++; $display("FAIL reset_maddr got=%h exp=0", maddr); end
    endtask

    task automatic test_single();
        bit seen;
        valid[2] = 1'b1;
        addr[2]  = 8'h15;
        tick();
        wait_req(seen);
        checks++; if (!seen) begin errors++; $display("FAIL single_req got=%b exp=1", mvld); end
        checks++; if (maddr !== 8'h15) begin errors++; $display("FAIL single_addr got=%h exp=15", maddr); end
        addr[2] = 8'h99;
        tick();
        tick();
        checks++; if (mvld !== 1'b1 || maddr !== 8'h15) begin
            errors++; $display("FAIL single_hold got=%b/%h exp=1/15", mvld, maddr);
        end
        mrdy  = 1'b1;
        mdata = 16'hABCD;
        tick();
        mrdy  = 1'b0;
        checks++; if (rdy !== 4'b0100) begin errors++; $display("FAIL single_pulse got=%b exp=0100", rdy); end
        checks++; if (rdata[2] !== 16'hABCD) begin errors++; $display("FAIL single_data got=%h exp=abcd", rdata[2]); end
        checks++; if (mvld !== 1'b0) begin errors++; $display("FAIL single_mvld_drop got=%b exp=0", mvld); end
        valid[2] = 1'b0;
        tick();
        checks++; if (rdy !== '0) begin errors++; $display("FAIL single_pulse_width got=%b exp=0", rdy); end
        checks++; if (rdata[2] !== 16'hABCD) begin errors++; $display("FAIL single_retain got=%h exp=abcd", rdata[2]); end
        tick();
        checks++; if (mvld !== 1'b0) begin errors++; $display("FAIL single_no_regrant got=%b exp=0", mvld); end
    endtask

    // Pointer sits at 3 after the single request: 3 before 1, then pointer 2 makes 2 beat 0.
    task automatic test_wrap();
        int               order [4] = '{3, 1, 2, 0};
        logic [AB-1:0]    a     [4] = '{8'h43, 8'h21, 8'h23, 8'h01};
        logic [DB-1:0]    d;
        bit               seen;
        int               c;
        valid[3] = 1'b1; addr[3] = 8'h43;
        valid[1] = 1'b1; addr[1] = 8'h21;
        tick();
        for (int j = 0; j < 4; j++) begin
            if (j == 2) begin
                valid[0] = 1'b1; addr[0] = 8'h01;
                valid[2] = 1'b1; addr[2] = 8'h23;
            end
            wait_req(seen);
            c = order[j];
            checks++; if (!seen) begin errors++; $display("FAIL wrap_req%0d got=%b exp=1", j, mvld); end
            checks++; if (maddr !== a[j]) begin errors++; $display("FAIL wrap_addr%0d got=%h exp=%h", j, maddr, a[j]); end
            // Dropping valid while granted must not cancel the transaction.
            if (j == 1) valid[c] = 1'b0;
            d = DB'($urandom);
            respond(j + 1, d);
            checks++; if (rdy !== (N'(1) << c)) begin errors++; $display("FAIL wrap_pulse%0d got=%b exp consumer %0d", j, rdy, c); end
            checks++; if (rdata[c] !== d) begin errors++; $display("FAIL wrap_data%0d got=%h exp=%h", j, rdata[c], d); end
            valid[c] = 1'b0;
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [AB-1:0] a [N];
        logic [DB-1:0] d;
        bit            seen;
        do_reset();
        for (int i = 0; i < N; i++) begin
            a[i]    = AB'($urandom);
            addr[i] = a[i];
        end
        valid = '1;
        tick();
        for (int j = 0; j < N; j++) begin
            wait_req(seen);
            checks++; if (!seen) begin errors++; $display("FAIL rr_req%0d got=%b exp=1", j, mvld); end
            checks++; if (maddr !== a[j]) begin errors++; $display("FAIL rr_addr%0d got=%h exp=%h", j, maddr, a[j]); end
            d = DB'($urandom);
            respond(int'($urandom_range(1, 4)), d);
            checks++; if (rdy !== (N'(1) << j)) begin errors++; $display("FAIL rr_pulse%0d got=%b exp consumer %0d", j, rdy, j); end
            checks++; if (rdata[j] !== d) begin errors++; $display("FAIL rr_data%0d got=%h exp=%h", j, rdata[j], d); end
            valid[j] = 1'b0;
            tick();
            checks++; if (rdy !== '0) begin errors++; $display("FAIL rr_pulse_width%0d got=%b exp=0", j, rdy); end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (mvld !== 1'b0) begin errors++; $display("FAIL rr_served_twice got=%b exp=0", mvld); end
        end
    endtask

    task automatic test_no_double();
        bit seen;
        int reqs;
        valid[0] = 1'b1;
        addr[0]  = 8'h77;
        tick();
        wait_req(seen);
        reqs = seen ? 1 : 0;
        respond(2, 16'h1234);
        checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL nodbl_pulse got=%b exp=0001", rdy); end
        // Fetcher keeps valid through the edge that registers its ready, then lets go.
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) valid[0] = 1'b0;
            if (mvld === 1'b1) reqs++;
        end
        checks++; if (reqs !== 1) begin errors++; $display("FAIL nodbl_requests got=%0d exp=1", reqs); end
    endtask

    task automatic test_stray_ready();
        bit seen;
        do_reset();
        mrdy  = 1'b1;
        mdata = 16'hFFFF;
        tick();
        mrdy  = 1'b0;
        checks++; if (rdy !== '0 || mvld !== 1'b0 || rdata !== '0) begin
            errors++; $display("FAIL stray_reset_idle got rdy=%b mvld=%b data=%h exp all 0", rdy, mvld, rdata);
        end
        valid[1] = 1'b1;
        addr[1]  = 8'h3C;
        tick();
        wait_req(seen);
        respond(1, 16'h5A5A);
        valid[1] = 1'b0;
        tick();
        tick();
        mrdy  = 1'b1;
        mdata = 16'hFFFF;
        tick();
        tick();
        mrdy  = 1'b0;
        checks++; if (rdy !== '0 || mvld !== 1'b0) begin errors++; $display("FAIL stray_ctrl got rdy=%b mvld=%b exp 0/0", rdy, mvld); end
        checks++; if (rdata[1] !== 16'h5A5A) begin errors++; $display("FAIL stray_data got=%h exp=5a5a", rdata[1]); end
        checks++; if (maddr !== 8'h3C) begin errors++; $display("FAIL stray_addr got=%h exp=3c", maddr); end
    endtask

    task automatic test_async_reset();
        bit seen;
        valid[1] = 1'b1;
        addr[1]  = 8'h42;
        tick();
        wait_req(seen);
        checks++; if (!seen) begin errors++; $display("FAIL areset_req got=%b exp=1", mvld); end
        #2 reset = 1'b0;
        #1;
        checks++; if (mvld !== 1'b0) begin errors++; $display("FAIL areset_immediate got=%b exp=0", mvld); end
        valid = '0;
        tick();
        reset = 1'b1;
        mrdy  = 1'b1;
        mdata = 16'hBEEF;
        tick();
        mrdy  = 1'b0;
        checks++; if (rdy !== '0) begin errors++; $display("FAIL areset_pulse got=%b exp=0", rdy); end
        tick();
        checks++; if (rdy !== '0 || rdata !== '0 || mvld !== 1'b0) begin
            errors++; $display("FAIL areset_state got rdy=%b data=%h mvld=%b exp all 0", rdy, rdata, mvld);
        end
    endtask

    // Transaction-level reference: one memory request in flight, pulse one cycle, search from last served + 1.
    task automatic test_random();
        logic [N-1:0]         m_rdy;
        logic [N-1:0][DB-1:0] m_data;
        logic [AB-1:0]        m_addr;
        bit                   m_busy;
        int                   m_ptr;
        int                   m_cur;
        int                   c;
        bit                   hold [N];
        do_reset();
        m_rdy = '0; m_data = '0; m_addr = '0; m_busy = 1'b0; m_ptr = 0; m_cur = 0;
        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            // Advance the model by the edge just taken, using the inputs it sampled.
            if (m_rdy != '0) begin
                m_rdy = '0;
            end else if (m_busy) begin
                if (mrdy) begin
                    m_busy        = 1'b0;
                    m_data[m_cur] = mdata;
                    m_rdy         = N'(1) << m_cur;
                    m_ptr         = (m_cur + 1) % N;
                end
            end else begin
                for (int s = 0; s < N; s++) begin
                    c = (m_ptr + s) % N;
                    if (valid[c]) begin
                        m_cur  = c;
                        m_busy = 1'b1;
                        m_addr = addr[c];
                        break;
                    end
                end
            end
            checks++; if (mvld !== m_busy) begin errors++; $display("FAIL rand_mvld cyc=%0d got=%b exp=%b", cyc, mvld, m_busy); end
            checks++; if (maddr !== m_addr) begin errors++; $display("FAIL rand_maddr cyc=%0d got=%h exp=%h", cyc, maddr, m_addr); end
            checks++; if (rdy !== m_rdy) begin errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, rdy, m_rdy); end
            checks++; if (rdata !== m_data) begin errors++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, rdata, m_data); end
            checks++; if ($countones(rdy) > 1) begin errors++; $display("FAIL rand_onehot cyc=%0d got=%b exp at most one bit", cyc, rdy); end
            // Fetcher behaviour, reacting to what the DUT shows.
            for (int i = 0; i < N; i++) begin
                if (rdy[i]) begin
                    if ($urandom_range(0, 1) == 0) valid[i] = 1'b0;
                    else                           hold[i]  = 1'b1;
                end else if (hold[i]) begin
                    hold[i]  = 1'b0;
                    valid[i] = 1'b0;
                end else if (!valid[i] && $urandom_range(0, 3) == 0) begin
                    valid[i] = 1'b1;
                    addr[i]  = AB'($urandom);
                end else if (valid[i] && $urandom_range(0, 15) == 0) begin
                    addr[i]  = AB'($urandom);
                end
            end
            mrdy  = mvld ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            mdata = DB'($urandom);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_no_double();
        test_stray_ready();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
